// File: rtl/i_fetch_queue.sv
// Instruction prefetch queue: fetches bytes from instruction memory into a small FIFO.
// A redirect flushes the queue and restarts fetching at the new target after a bubble.
module i_fetch_queue #(
    parameter int ADDR_WIDTH = 16,
    parameter int FIFO_DEPTH = 4,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  i_req,
    output logic [ADDR_WIDTH-1:0] i_addr,
    input  logic                  i_ack,
    input  logic [7:0]            i_rdata,
    input  logic                  redir_valid,
    input  logic [ADDR_WIDTH-1:0] redir_addr,
    output logic                  f_valid,
    output logic [7:0]            f_instr,
    output logic [ADDR_WIDTH-1:0] f_pc,
    input  logic                  f_ready
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_BUBBLE
    } state_t;

    state_t               state;
    logic [7:0]           mem_instr [FIFO_DEPTH];
    logic [ADDR_WIDTH-1:0] mem_pc   [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_ptr;
    logic [CNT_W-1:0]     count;
    logic [CNT_W-1:0]     count_next;
    logic                 ack_ok;
    logic                 push;
    logic                 pop;

    // An ack only counts against a live request, and a redirect discards it.
    assign ack_ok  = i_ack & i_req;
    assign push    = ack_ok & ~redir_valid;
    assign f_valid = (count != '0);
    assign pop     = f_valid & f_ready;
    assign f_instr = mem_instr[rd_ptr];
    assign f_pc    = mem_pc[rd_ptr];

    always_comb begin
        count_next = count + CNT_W'(push) - CNT_W'(pop);
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_instr[wr_ptr] <= i_rdata;
            mem_pc[wr_ptr]    <= i_addr;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= S_BUBBLE;
            i_req  <= 1'b0;
            i_addr <= RESET_PC;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (redir_valid) begin
            state  <= S_BUBBLE;
            i_req  <= 1'b0;
            i_addr <= redir_addr;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            count <= count_next;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            unique case (state)
                S_BUBBLE: begin
                    state <= S_REQ;
                    i_req <= 1'b1;
                end
                S_IDLE: begin
                    if (count_next < DEPTH_C) begin
                        state <= S_REQ;
                        i_req <= 1'b1;
                    end
                end
                S_REQ: begin
                    if (ack_ok) begin
                        i_addr <= i_addr + 1'b1;
                        if (count_next >= DEPTH_C) begin
                            state <= S_IDLE;
                            i_req <= 1'b0;
                        end
                    end
                end
                default: begin
                    state <= S_BUBBLE;
                    i_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_i_fetch_queue.sv
// Directed bench for i_fetch_queue: cycle vectors plus an async-reset sequence.
module tb_i_fetch_queue;

    typedef struct {
        logic        rst;
        logic        fr;
        logic        rv;
        logic [15:0] ra;
        logic        ack;
        logic        req;
        logic [15:0] addr;
        logic        fv;
        logic [15:0] pc;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_req;
    logic [15:0] i_addr;
    logic        i_ack;
    logic [7:0]  i_rdata;
    logic        redir_valid = 1'b0;
    logic [15:0] redir_addr = 16'h0;
    logic        f_valid;
    logic [7:0]  f_instr;
    logic [15:0] f_pc;
    logic        f_ready = 1'b0;
    logic        ack_en = 1'b0;
    logic        manual = 1'b0;
    logic        ack_man = 1'b0;

    int checks = 0;
    int failures = 0;
    vec_t tbl[$];

    function automatic logic [7:0] mem_byte(input logic [15:0] a);
        return a[7:0] ^ 8'h5A;
    endfunction

    function automatic vec_t v(input logic r, input logic fr, input logic rv,
                               input logic [15:0] ra, input logic ack,
                               input logic req, input logic [15:0] addr,
                               input logic fv, input logic [15:0] pc);
        vec_t x;
        x.rst = r; x.fr = fr; x.rv = rv; x.ra = ra; x.ack = ack;
        x.req = req; x.addr = addr; x.fv = fv; x.pc = pc;
        return x;
    endfunction

    assign i_ack   = manual ? ack_man : (ack_en & i_req);
    assign i_rdata = mem_byte(i_addr);

    always #5 clk = ~clk;

    i_fetch_queue #(
        .ADDR_WIDTH(16),
        .FIFO_DEPTH(4),
        .RESET_PC(16'h0000)
    ) dut (
        .clk(clk),
        .rst(rst),
        .i_req(i_req),
        .i_addr(i_addr),
        .i_ack(i_ack),
        .i_rdata(i_rdata),
        .redir_valid(redir_valid),
        .redir_addr(redir_addr),
        .f_valid(f_valid),
        .f_instr(f_instr),
        .f_pc(f_pc),
        .f_ready(f_ready)
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic req,
                           input logic [15:0] addr, input logic fv,
                           input logic [15:0] pc);
        chk({tag, ".i_req"}, 32'(i_req), 32'(req));
        chk({tag, ".i_addr"}, 32'(i_addr), 32'(addr));
        chk({tag, ".f_valid"}, 32'(f_valid), 32'(fv));
        if (fv) begin
            chk({tag, ".f_pc"}, 32'(f_pc), 32'(pc));
            chk({tag, ".f_instr"}, 32'(f_instr), 32'(mem_byte(pc)));
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // stream from reset, redirect over an ack
        tbl.push_back(v(0,1,0,16'h0000,1, 1,16'h0000,0,16'h0000));
        tbl.push_back(v(0,1,0,16'h0000,1, 1,16'h0001,1,16'h0000));
        tbl.push_back(v(0,1,0,16'h0000,1, 1,16'h0002,1,16'h0001));
        tbl.push_back(v(0,1,0,16'h0000,1, 1,16'h0003,1,16'h0002));
        tbl.push_back(v(0,1,0,16'h0000,1, 1,16'h0004,1,16'h0003));
        tbl.push_back(v(0,1,0,16'h0000,1, 1,16'h0005,1,16'h0004));
        tbl.push_back(v(0,1,1,16'h0100,1, 0,16'h0100,0,16'h0000));
        tbl.push_back(v(0,1,0,16'h0000,1, 1,16'h0100,0,16'h0000));
        tbl.push_back(v(0,1,0,16'h0000,1, 1,16'h0101,1,16'h0100));
        tbl.push_back(v(0,1,0,16'h0000,1, 1,16'h0102,1,16'h0101));
        // stalled consumer after reset fills exactly four entries
        tbl.push_back(v(1,0,0,16'h0000,1, 0,16'h0000,0,16'h0000));
        tbl.push_back(v(0,0,0,16'h0000,1, 1,16'h0000,0,16'h0000));
        tbl.push_back(v(0,0,0,16'h0000,1, 1,16'h0001,1,16'h0000));
        tbl.push_back(v(0,0,0,16'h0000,1, 1,16'h0002,1,16'h0000));
        tbl.push_back(v(0,0,0,16'h0000,1, 1,16'h0003,1,16'h0000));
        tbl.push_back(v(0,0,0,16'h0000,1, 0,16'h0004,1,16'h0000));
        tbl.push_back(v(0,0,0,16'h0000,1, 0,16'h0004,1,16'h0000));
        tbl.push_back(v(0,0,0,16'h0000,1, 0,16'h0004,1,16'h0000));
        tbl.push_back(v(0,1,0,16'h0000,1, 1,16'h0004,1,16'h0001));
        tbl.push_back(v(0,1,0,16'h0000,1, 1,16'h0005,1,16'h0002));
        tbl.push_back(v(0,1,0,16'h0000,1, 1,16'h0006,1,16'h0003));
        tbl.push_back(v(0,1,0,16'h0000,1, 1,16'h0007,1,16'h0004));
        // address wrap at 0xFFFF
        tbl.push_back(v(0,1,1,16'hFFFF,1, 0,16'hFFFF,0,16'h0000));
        tbl.push_back(v(0,1,0,16'h0000,1, 1,16'hFFFF,0,16'h0000));
        tbl.push_back(v(0,1,0,16'h0000,1, 1,16'h0000,1,16'hFFFF));
        tbl.push_back(v(0,1,0,16'h0000,1, 1,16'h0001,1,16'h0000));
        // fill, then redirect with a simultaneous pop
        tbl.push_back(v(0,0,0,16'h0000,1, 1,16'h0002,1,16'h0000));
        tbl.push_back(v(0,0,0,16'h0000,1, 1,16'h0003,1,16'h0000));
        tbl.push_back(v(0,0,0,16'h0000,1, 0,16'h0004,1,16'h0000));
        tbl.push_back(v(0,1,1,16'h0200,1, 0,16'h0200,0,16'h0000));
        tbl.push_back(v(0,1,0,16'h0000,1, 1,16'h0200,0,16'h0000));
        tbl.push_back(v(0,1,0,16'h0000,1, 1,16'h0201,1,16'h0200));
        // held redirect uses the last target
        tbl.push_back(v(0,1,1,16'h0300,1, 0,16'h0300,0,16'h0000));
        tbl.push_back(v(0,1,1,16'h0340,1, 0,16'h0340,0,16'h0000));
        tbl.push_back(v(0,1,0,16'h0000,1, 1,16'h0340,0,16'h0000));
        tbl.push_back(v(0,1,0,16'h0000,1, 1,16'h0341,1,16'h0340));
        // request held stable without ack
        tbl.push_back(v(0,1,0,16'h0000,0, 1,16'h0341,0,16'h0000));
        tbl.push_back(v(0,1,0,16'h0000,0, 1,16'h0341,0,16'h0000));
        tbl.push_back(v(0,1,0,16'h0000,1, 1,16'h0342,1,16'h0341));

        repeat (2) @(posedge clk);
        #1;
        chk("reset.i_req", 32'(i_req), 32'h0);
        chk("reset.i_addr", 32'(i_addr), 32'h0);
        chk("reset.f_valid", 32'(f_valid), 32'h0);

        for (int k = 0; k < tbl.size(); k++) begin
            @(negedge clk);
            rst         = tbl[k].rst;
            f_ready     = tbl[k].fr;
            redir_valid = tbl[k].rv;
            redir_addr  = tbl[k].ra;
            ack_en      = tbl[k].ack;
            tick();
            chk_out($sformatf("vec%0d", k), tbl[k].req, tbl[k].addr,
                    tbl[k].fv, tbl[k].pc);
        end

        // async reset during a slow request; the late ack is ignored
        @(negedge clk);
        redir_valid = 1'b0;
        f_ready = 1'b1;
        manual = 1'b1;
        ack_man = 1'b0;
        rst = 1'b1;
        tick();
        @(negedge clk);
        rst = 1'b0;
        tick();
        chk_out("slow.req", 1'b1, 16'h0000, 1'b0, 16'h0000);
        tick();
        chk_out("slow.wait", 1'b1, 16'h0000, 1'b0, 16'h0000);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk_out("slow.async", 1'b0, 16'h0000, 1'b0, 16'h0000);
        @(negedge clk);
        ack_man = 1'b1;
        tick();
        chk_out("slow.lateack", 1'b0, 16'h0000, 1'b0, 16'h0000);
        @(negedge clk);
        rst = 1'b0;
        tick();
        chk_out("slow.restart", 1'b1, 16'h0000, 1'b0, 16'h0000);
        @(negedge clk);
        ack_man = 1'b0;
        tick();
        chk_out("slow.hold", 1'b1, 16'h0000, 1'b0, 16'h0000);
        @(negedge clk);
        ack_man = 1'b1;
        tick();
        chk_out("slow.data", 1'b1, 16'h0001, 1'b1, 16'h0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
